// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: glyph table, bit positions, bus payload.
// Glyph order matches the display encoder so both ends use one table.
package seg7_pkg;

  // Bit positions on the {dp,g,f,e,d,c,b,a} bus
  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  localparam int unsigned SEG_W      = 7;
  localparam int unsigned BUS_W      = 8;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_GLYPHS = 16;
  localparam int unsigned ERR_CNT_W  = 8;

  // Hex glyphs, active-high, bit 0 = segment a
  localparam logic [SEG_W-1:0] GLYPH_0 = 7'h3F;
  localparam logic [SEG_W-1:0] GLYPH_1 = 7'h06;
  localparam logic [SEG_W-1:0] GLYPH_2 = 7'h5B;
  localparam logic [SEG_W-1:0] GLYPH_3 = 7'h4F;
  localparam logic [SEG_W-1:0] GLYPH_4 = 7'h66;
  localparam logic [SEG_W-1:0] GLYPH_5 = 7'h6D;
  localparam logic [SEG_W-1:0] GLYPH_6 = 7'h7D;
  localparam logic [SEG_W-1:0] GLYPH_7 = 7'h07;
  localparam logic [SEG_W-1:0] GLYPH_8 = 7'h7F;
  localparam logic [SEG_W-1:0] GLYPH_9 = 7'h6F;
  localparam logic [SEG_W-1:0] GLYPH_A = 7'h77;
  localparam logic [SEG_W-1:0] GLYPH_B = 7'h7C;
  localparam logic [SEG_W-1:0] GLYPH_C = 7'h39;
  localparam logic [SEG_W-1:0] GLYPH_D = 7'h5E;
  localparam logic [SEG_W-1:0] GLYPH_E = 7'h79;
  localparam logic [SEG_W-1:0] GLYPH_F = 7'h71;

  localparam logic [SEG_W-1:0] BLANK = 7'h00;

  // Table indexed by digit value: GLYPHS[d] is the pattern for d
  localparam logic [NUM_GLYPHS-1:0][SEG_W-1:0] GLYPHS = {
    GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C,
    GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
    GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4,
    GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
  };

  // One sample of the segment bus; dp sits at bit SEG_DP
  typedef struct packed {
    logic             dp;
    logic [SEG_W-1:0] seg;
  } seg_bus_t;

  // Classification of an accepted pattern
  typedef enum logic [1:0] {
    CLASS_GLYPH = 2'd0,
    CLASS_BLANK = 2'd1,
    CLASS_ERR   = 2'd2
  } seg_class_e;

  // Pattern for a digit, shared with the encoder side
  function automatic logic [SEG_W-1:0] glyph_of(input logic [DIGIT_W-1:0] digit);
    return GLYPHS[digit];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational decode of seg[6:0] back to a hex digit.
// Ports:
//   seg        - segment pattern {g,f,e,d,c,b,a}
//   hit_c      - pattern is one of the 16 hex glyphs
//   is_blank_c - all segments off
//   digit_c    - decoded digit (0 when not a hit)
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0]   seg,
  output logic               hit_c,
  output logic               is_blank_c,
  output logic [DIGIT_W-1:0] digit_c
);

  // Table search; glyphs are unique so at most one entry matches
  always_comb begin
    hit_c      = 1'b0;
    digit_c    = '0;
    is_blank_c = (seg == BLANK);
    for (int unsigned i = 0; i < NUM_GLYPHS; i++) begin
      if (seg == GLYPHS[i]) begin
        hit_c   = 1'b1;
        digit_c = DIGIT_W'(i);
      end
    end
  end

endmodule

// File: rtl/seg7_capture.sv
// Loopback receiver for the seven-segment bus: synchronizes the raw lines,
// waits for a pattern to hold for STABLE_CYCLES samples, then reports it
// once as a hex digit, a blank, or an error.
// Ports:
//   CLK, RST_N  - clock, async active-low reset
//   i_seg       - raw segment lines {dp,g,f,e,d,c,b,a}
//   o_val       - last decoded hex digit
//   o_dp        - dp of last accepted pattern
//   o_valid     - 1-cycle pulse, glyph accepted
//   o_blank     - 1-cycle pulse, blank accepted
//   o_err       - 1-cycle pulse, undecodable pattern accepted
//   o_err_count - saturating count of o_err pulses
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16
)(
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [BUS_W-1:0]     i_seg,
  output logic [DIGIT_W-1:0]   o_val,
  output logic                 o_dp,
  output logic                 o_valid,
  output logic                 o_blank,
  output logic                 o_err,
  output logic [ERR_CNT_W-1:0] o_err_count
);

  localparam int unsigned CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  logic [BUS_W-1:0]   sync_meta;
  seg_bus_t           sync_q;
  seg_bus_t           cand_q;
  seg_bus_t           acc_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               same_c;
  logic               accept_c;
  logic               hit_c;
  logic               blank_c;
  logic [DIGIT_W-1:0] digit_c;
  seg_class_e         class_c;

  // Two-flop synchronizer on the asynchronous segment lines
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= i_seg;
      sync_q    <= seg_bus_t'(sync_meta);
    end
  end

  assign same_c = (sync_q == cand_q);

  // Stability filter: any change reloads the candidate and restarts counting
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cand_q <= '0;
      cnt_q  <= '0;
    end else if (!same_c) begin
      cand_q <= sync_q;
      cnt_q  <= '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Report only stable patterns that differ from the last one reported
  assign accept_c = same_c && (cnt_q == CNT_MAX) && (cand_q != acc_q);

  seg7_decode u_decode (
    .seg        (cand_q.seg),
    .hit_c      (hit_c),
    .is_blank_c (blank_c),
    .digit_c    (digit_c)
  );

  // Classification priority: glyph, then blank, else error
  always_comb begin
    class_c = CLASS_ERR;
    if (hit_c) begin
      class_c = CLASS_GLYPH;
    end else if (blank_c) begin
      class_c = CLASS_BLANK;
    end
  end

  // Accepted pattern, result registers and one-cycle pulses
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_q       <= '0;
      o_val       <= '0;
      o_dp        <= 1'b0;
      o_valid     <= 1'b0;
      o_blank     <= 1'b0;
      o_err       <= 1'b0;
      o_err_count <= '0;
    end else begin
      o_valid <= 1'b0;
      o_blank <= 1'b0;
      o_err   <= 1'b0;
      if (accept_c) begin
        acc_q <= cand_q;
        o_dp  <= cand_q.dp;
        unique case (class_c)
          CLASS_GLYPH: begin
            o_val   <= digit_c;
            o_valid <= 1'b1;
          end
          CLASS_BLANK: begin
            o_blank <= 1'b1;
          end
          default: begin
            o_err <= 1'b1;
            if (o_err_count != ERR_MAX) begin
              o_err_count <= o_err_count + ERR_CNT_W'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// Scoreboard bench for seg7_capture: stimulus pushes expected reports,
// a monitor pops and compares whenever the DUT pulses.
module tb_seg7_capture;

  localparam int unsigned S = 16;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] i_seg;
  logic [3:0] o_val;
  logic       o_dp;
  logic       o_valid;
  logic       o_blank;
  logic       o_err;
  logic [7:0] o_err_count;

  seg7_capture #(.STABLE_CYCLES(S)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .i_seg       (i_seg),
    .o_val       (o_val),
    .o_dp        (o_dp),
    .o_valid     (o_valid),
    .o_blank     (o_blank),
    .o_err       (o_err),
    .o_err_count (o_err_count)
  );

  always #31 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // kind is {err, blank, valid}
  typedef struct {
    logic [2:0]  kind;
    logic [3:0]  val;
    logic        dp;
    logic [7:0]  cnt;
    int unsigned at;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model of the reported state
  logic [7:0] m_acc = 8'h00;
  logic [3:0] m_val = 4'h0;
  logic       m_dp  = 1'b0;
  logic [7:0] m_cnt = 8'h00;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive a pattern at a negedge and hold it; long holds of a new pattern
  // predict one report S+3 cycle-counts later
  task automatic apply(input logic [7:0] pat, input int unsigned hold);
    exp_t e;
    bit   found;
    i_seg = pat;
    if (hold >= S + 3 && pat != m_acc) begin
      found = 1'b0;
      for (int i = 0; i < 16; i++) begin
        if (tbl[i] == pat[6:0]) begin
          found = 1'b1;
          m_val = 4'(i);
        end
      end
      m_acc = pat;
      m_dp  = pat[7];
      if (found) begin
        e.kind = 3'b001;
      end else if (pat[6:0] == 7'h00) begin
        e.kind = 3'b010;
      end else begin
        e.kind = 3'b100;
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      end
      e.val = m_val;
      e.dp  = m_dp;
      e.cnt = m_cnt;
      e.at  = cyc + S + 3;
      q.push_back(e);
    end
    repeat (hold) @(negedge CLK);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_val"},     int'(o_val),       0);
    check({tag, "_dp"},      int'(o_dp),        0);
    check({tag, "_pulses"},  int'({o_err, o_blank, o_valid}), 0);
    check({tag, "_errcnt"},  int'(o_err_count), 0);
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation
  always @(negedge CLK) begin
    if (RST_N === 1'b1 && (o_valid || o_blank || o_err)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got kind=%b val=%0d dp=%0d expected no pulse (cycle %0d)",
                 {o_err, o_blank, o_valid}, o_val, o_dp, cyc);
      end else begin
        mon_e = q.pop_front();
        check("pulse_kind",   int'({o_err, o_blank, o_valid}), int'(mon_e.kind));
        check("pulse_cycle",  int'(cyc),         int'(mon_e.at));
        check("pulse_val",    int'(o_val),       int'(mon_e.val));
        check("pulse_dp",     int'(o_dp),        int'(mon_e.dp));
        check("pulse_errcnt", int'(o_err_count), int'(mon_e.cnt));
      end
    end
  end

  initial begin
    RST_N = 1'b0;
    i_seg = 8'h00;
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    RST_N = 1'b1;
    @(negedge CLK);

    // Single glyph, held well beyond acceptance
    apply(8'h5B, 60);

    // Full table with dp set
    for (int i = 0; i < 16; i++) begin
      apply({1'b1, tbl[i]}, 40);
    end
    check("sweep_errcnt", int'(o_err_count), 0);

    // Glyph, blank, then dp-only change of blank
    apply(8'h3F, 40);
    apply(8'h00, 40);
    apply(8'h80, 40);

    // Glitch away and back to the accepted value
    apply(8'h3F, 40);
    apply(8'h06, 10);
    apply(8'h3F, 40);
    check("glitch_val", int'(o_val), 0);

    // Error saturation
    for (int i = 0; i < 260; i++) begin
      apply((i % 2 == 0) ? 8'h7E : 8'h01, 20);
    end
    check("sat_errcnt", int'(o_err_count), 255);
    check("sat_val",    int'(o_val),       0);

    // Reset while the filter counter is at 10 on pattern 66
    apply(8'h66, 13);
    RST_N = 1'b0;
    m_acc = 8'h00;
    m_val = 4'h0;
    m_dp  = 1'b0;
    m_cnt = 8'h00;
    @(negedge CLK);
    check_all_zero("midreset");
    RST_N = 1'b1;
    apply(8'h66, 40);

    repeat (10) @(negedge CLK);
    check("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
